i2c_eeprom_slave: RTL

Synthesizable, parametrised I2C EEPROM slave that runs on a system clock and oversamples the open-drain SCL/SDA bus. It supports byte/page write, random read, current-address read and sequential read with address auto-increment. It replaces the single-byte, simulation-only EEPROM model in board-level benches and can also be built into FPGA test fixtures. Memory is an internal register array of 2**ADDR_W bytes.

---
 rtl/i2c_eeprom_slave.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/i2c_eeprom_slave.sv
// I2C EEPROM slave with 2**ADDR_W bytes: page write, random/current/sequential read.
// Bus events lag the pins by ~3 clk through the synchronisers; SCL is never stretched.
module i2c_eeprom_slave #(
    parameter logic [6:0] DEV_ADDR  = 7'h47,
    parameter int         ADDR_W    = 8,
    parameter int         PAGE_SIZE = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl,
    inout  wire               sda,
    output logic              busy,
    output logic              wr_pulse,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              rd_nack
);
    localparam int ADDR_BYTES = (ADDR_W <= 8) ? 1 : 2;
    localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(PAGE_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DEV, S_ACK, S_WADDR, S_WDATA, S_RDATA, S_RACK, S_WAIT
    } state_t;

    state_t            r_state, r_nxt;
    logic [3:0]        r_cnt;
    logic [6:0]        r_shift;
    logic [7:0]        r_tx, r_hi;
    logic              r_flag, r_abyte, r_sda_oe;
    logic [ADDR_W-1:0] r_ptr;
    logic [7:0]        r_mem [2**ADDR_W];
    logic              r_scl_s1, r_scl_s2, r_scl_s3, r_sda_s1, r_sda_s2, r_sda_s3;

    logic              w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]        w_byte, w_rd_byte;
    logic [ADDR_W-1:0] w_ptr_page;

    assign sda        = r_sda_oe ? 1'b0 : 1'bz;
    assign w_scl_rise = r_scl_s2 & ~r_scl_s3;
    assign w_scl_fall = ~r_scl_s2 & r_scl_s3;
    assign w_start    = r_scl_s2 & ~r_sda_s2 & r_sda_s3;
    assign w_stop     = r_scl_s2 & r_sda_s2 & ~r_sda_s3;
    assign w_byte     = {r_shift, r_sda_s2};
    assign w_rd_byte  = r_mem[r_ptr];
    assign w_ptr_page = (r_ptr & ~PAGE_MASK) | ((r_ptr + ADDR_W'(1)) & PAGE_MASK);

    // Synchronisers reset to the idle-bus level so reset release creates no edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            {r_scl_s1, r_scl_s2, r_scl_s3} <= 3'b111;
            {r_sda_s1, r_sda_s2, r_sda_s3} <= 3'b111;
        end else begin
            r_scl_s1 <= scl;
            r_scl_s2 <= r_scl_s1;
            r_scl_s3 <= r_scl_s2;
            r_sda_s1 <= sda;
            r_sda_s2 <= r_sda_s1;
            r_sda_s3 <= r_sda_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_nxt    <= S_IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_tx     <= '0;
            r_hi     <= '0;
            r_flag   <= 1'b0;
            r_abyte  <= 1'b0;
            r_ptr    <= '0;
            r_sda_oe <= 1'b0;
            busy     <= 1'b0;
            wr_pulse <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            rd_nack  <= 1'b0;
        end else begin
            wr_pulse <= 1'b0;
            rd_nack  <= 1'b0;
            if (w_start) begin
                r_state  <= S_DEV;
                r_cnt    <= '0;
                r_sda_oe <= 1'b0;
                busy     <= 1'b1;
            end else if (w_stop) begin
                r_state  <= S_IDLE;
                r_sda_oe <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (r_state)
                    S_DEV, S_WADDR, S_WDATA: if (w_scl_rise) begin
                        r_shift <= w_byte[6:0];
                        r_cnt   <= r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            r_state <= S_ACK;
                            r_flag  <= 1'b0;
                            if (r_state == S_DEV) begin
                                if (w_byte[7:1] != DEV_ADDR) r_state <= S_WAIT;
                                r_nxt   <= w_byte[0] ? S_RDATA : S_WADDR;
                                r_abyte <= 1'b0;
                            end else if (r_state == S_WADDR) begin
                                r_hi    <= w_byte;
                                r_abyte <= 1'b1;
                                if (r_abyte || ADDR_BYTES == 1) begin
                                    r_nxt <= S_WDATA;
                                    r_ptr <= (ADDR_BYTES == 1) ? ADDR_W'(w_byte)
                                                               : ADDR_W'({r_hi, w_byte});
                                end else begin
                                    r_nxt <= S_WADDR;
                                end
                            end else begin
                                r_mem[r_ptr] <= w_byte;
                                wr_pulse     <= 1'b1;
                                wr_addr      <= r_ptr;
                                wr_data      <= w_byte;
                                r_ptr        <= w_ptr_page;
                                r_nxt        <= S_WDATA;
                            end
                        end
                    end
                    // First fall drives ACK, second fall ends it and may place a read MSB.
                    S_ACK: if (w_scl_fall) begin
                        if (!r_flag) begin
                            r_sda_oe <= 1'b1;
                            r_flag   <= 1'b1;
                        end else begin
                            r_state <= r_nxt;
                            r_cnt   <= '0;
                            if (r_nxt == S_RDATA) begin
                                r_tx     <= w_rd_byte;
                                r_sda_oe <= ~w_rd_byte[7];
                                r_ptr    <= r_ptr + ADDR_W'(1);
                            end else begin
                                r_sda_oe <= 1'b0;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (w_scl_rise) begin
                            r_cnt <= r_cnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_cnt == 4'd8) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= S_RACK;
                                r_flag   <= 1'b0;
                            end else begin
                                r_sda_oe <= ~r_tx[3'd7 - r_cnt[2:0]];
                            end
                        end
                    end
                    S_RACK: begin
                        if (w_scl_rise) begin
                            if (r_sda_s2) begin
                                rd_nack <= 1'b1;
                                r_state <= S_WAIT;
                            end else begin
                                r_flag <= 1'b1;
                            end
                        end else if (w_scl_fall && r_flag) begin
                            r_state  <= S_RDATA;
                            r_cnt    <= '0;
                            r_tx     <= w_rd_byte;
                            r_sda_oe <= ~w_rd_byte[7];
                            r_ptr    <= r_ptr + ADDR_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
